// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl_pkg                                         |
// | Brief   : Shared encodings for the pipeline hazard/interlock controller.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] c_FWD_RF      = 2'b00;
    localparam logic [1:0] c_FWD_EXE     = 2'b01;
    localparam logic [1:0] c_FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] c_FWD_MEM_LD  = 2'b11;

    localparam int         c_ST_W      = 2;
    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_STALL  = 2'd1;
    localparam logic [1:0] c_ST_FREEZE = 2'd2;

    localparam int c_SB_STAGES = 3;
    localparam int c_SB_EXE    = 0;
    localparam int c_SB_MEM    = 1;
    localparam int c_SB_WB     = 2;

    // Entry flag vector is {valid, wreg, m2reg}.
    localparam int c_SB_FLAG_W = 3;
    localparam int c_FLAG_V    = 2;
    localparam int c_FLAG_WR   = 1;
    localparam int c_FLAG_LD   = 0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl_if                                          |
// | Brief   : Decode-side controls in, pipeline sequencing controls out.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rn;
    logic             id_wreg;
    logic             id_m2reg;
    logic             id_branch;
    logic [1:0]       id_pcsource;
    logic             mem_busy;

    logic             stall;
    logic             bubble;
    logic             freeze;
    logic             flush_if;
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg,
               id_branch, id_pcsource, mem_busy,
        input  stall, bubble, freeze, flush_if, fwda, fwdb, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_rn, id_wreg, id_m2reg,
               id_branch, id_pcsource, mem_busy,
        output stall, bubble, freeze, flush_if, fwda, fwdb, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_sb_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hazard_sb_entry                                                  |
// | Brief   : One scoreboard slot {valid, wreg, m2reg, rn} with hold/clear.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_sb_entry
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  wire logic                   clk,
    input  wire logic                   clrn,
    input  wire logic                   i_hold,
    input  wire logic                   i_clear,
    input  wire logic [c_SB_FLAG_W-1:0] i_flags,
    input  wire logic [REG_W-1:0]       i_rn,
    output logic      [c_SB_FLAG_W-1:0] o_flags,
    output logic      [REG_W-1:0]       o_rn
);
    logic [c_SB_FLAG_W-1:0] r_flags;
    logic [REG_W-1:0]       r_rn;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_flags <= '0;
            r_rn    <= '0;
        end else if (!i_hold) begin
            if (i_clear) begin
                r_flags <= '0;
                r_rn    <= '0;
            end else begin
                r_flags <= i_flags;
                r_rn    <= i_rn;
            end
        end
    end

    assign o_flags = r_flags;
    assign o_rn    = r_rn;
endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_hazard_ctrl                                             |
// | Brief   : Five-stage pipeline interlock, forwarding and freeze controller. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter bit DELAY_SLOT = 1'b0,
    parameter int CNT_W      = 16
) (
    input wire logic             clk,
    input wire logic             clrn,
    pipeline_hazard_ctrl_if.slave bus
);
    logic [c_SB_FLAG_W-1:0] w_sb_flags_in [c_SB_STAGES];
    logic [REG_W-1:0]       w_sb_rn_in    [c_SB_STAGES];
    logic [c_SB_FLAG_W-1:0] w_sb_flags    [c_SB_STAGES];
    logic [REG_W-1:0]       w_sb_rn       [c_SB_STAGES];

    logic              w_stall, w_bubble, w_freeze, w_flush;
    logic [1:0]        w_fwda, w_fwdb;
    logic [c_ST_W-1:0] r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    function automatic logic f_match(input logic [c_SB_FLAG_W-1:0] flags,
                                     input logic [REG_W-1:0] rn,
                                     input logic [REG_W-1:0] r);
        return flags[c_FLAG_V] & flags[c_FLAG_WR] & (rn == r) & (r != '0);
    endfunction

    // A load still in EXE cannot forward; MEM then gets its chance.
    function automatic logic [1:0] f_fwd(input logic exe_hit, input logic exe_ld,
                                         input logic mem_hit, input logic mem_ld);
        if (exe_hit && !exe_ld) return c_FWD_EXE;
        if (mem_hit)            return mem_ld ? c_FWD_MEM_LD : c_FWD_MEM_ALU;
        return c_FWD_RF;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < c_SB_STAGES; gi++) begin : g_sb
            if (gi == c_SB_EXE) begin : g_head
                assign w_sb_flags_in[gi] = {1'b1, bus.id_wreg, bus.id_m2reg};
                assign w_sb_rn_in[gi]    = bus.id_rn;
            end else begin : g_tail
                assign w_sb_flags_in[gi] = w_sb_flags[gi-1];
                assign w_sb_rn_in[gi]    = w_sb_rn[gi-1];
            end
            hazard_sb_entry #(.REG_W(REG_W)) u_entry (
                .clk     (clk),
                .clrn    (clrn),
                .i_hold  (w_freeze),
                .i_clear ((gi == c_SB_EXE) ? w_bubble : 1'b0),
                .i_flags (w_sb_flags_in[gi]),
                .i_rn    (w_sb_rn_in[gi]),
                .o_flags (w_sb_flags[gi]),
                .o_rn    (w_sb_rn[gi])
            );
        end
    endgenerate

    logic w_exe_rs, w_exe_rt, w_mem_rs, w_mem_rt;
    logic w_exe_ld, w_mem_ld, w_load_use, w_br_haz, w_hazard;

    assign w_exe_rs   = bus.id_use_rs & f_match(w_sb_flags[c_SB_EXE], w_sb_rn[c_SB_EXE], bus.id_rs);
    assign w_exe_rt   = bus.id_use_rt & f_match(w_sb_flags[c_SB_EXE], w_sb_rn[c_SB_EXE], bus.id_rt);
    assign w_mem_rs   = bus.id_use_rs & f_match(w_sb_flags[c_SB_MEM], w_sb_rn[c_SB_MEM], bus.id_rs);
    assign w_mem_rt   = bus.id_use_rt & f_match(w_sb_flags[c_SB_MEM], w_sb_rn[c_SB_MEM], bus.id_rt);
    assign w_exe_ld   = w_sb_flags[c_SB_EXE][c_FLAG_LD];
    assign w_mem_ld   = w_sb_flags[c_SB_MEM][c_FLAG_LD];
    assign w_load_use = (w_exe_rs | w_exe_rt) & w_exe_ld;
    // Branches compare in decode, so even an EXE ALU result is too late.
    assign w_br_haz   = bus.id_branch & ((w_exe_rs | w_exe_rt) | ((w_mem_rs | w_mem_rt) & w_mem_ld));
    assign w_hazard   = w_load_use | w_br_haz;

    always_comb begin
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_freeze    = 1'b0;
        w_flush     = 1'b0;
        w_fwda      = c_FWD_RF;
        w_fwdb      = c_FWD_RF;
        w_state_nxt = c_ST_RUN;
        if (bus.mem_busy) begin
            w_state_nxt = c_ST_FREEZE;
            w_stall     = 1'b1;
            w_freeze    = 1'b1;
        end else if (w_hazard) begin
            w_state_nxt = c_ST_STALL;
            w_stall     = 1'b1;
            w_bubble    = 1'b1;
        end else if ((bus.id_pcsource != 2'b00) && !DELAY_SLOT) begin
            w_flush = 1'b1;
        end
        w_fwda = f_fwd(w_exe_rs, w_exe_ld, w_mem_rs, w_mem_ld);
        w_fwdb = f_fwd(w_exe_rt, w_exe_ld, w_mem_rt, w_mem_ld);
        if (!clrn) begin
            w_stall     = 1'b0;
            w_bubble    = 1'b0;
            w_freeze    = 1'b0;
            w_flush     = 1'b0;
            w_fwda      = c_FWD_RF;
            w_fwdb      = c_FWD_RF;
            w_state_nxt = c_ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= c_ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_stall | w_freeze) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // WB entry and FSM state are kept for observability only.
    logic w_unused;
    assign w_unused = ^{r_state, w_sb_flags[c_SB_WB], w_sb_rn[c_SB_WB]};

    assign bus.stall     = w_stall;
    assign bus.bubble    = w_bubble;
    assign bus.freeze    = w_freeze;
    assign bus.flush_if  = w_flush;
    assign bus.fwda      = w_fwda;
    assign bus.fwdb      = w_fwdb;
    assign bus.stall_cnt = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipeline_hazard_ctrl                                          |
// | Brief   : Directed plus random bench against an in-flight instruction model|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) bus0 ();
    pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(3))  bus1 ();

    pipeline_hazard_ctrl #(.REG_W(5), .DELAY_SLOT(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .clrn(clrn), .bus(bus0));
    pipeline_hazard_ctrl #(.REG_W(5), .DELAY_SLOT(1'b1), .CNT_W(3)) dut1 (
        .clk(clk), .clrn(clrn), .bus(bus1));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instructions in flight after decode: index 0 = EXE, 1 = MEM, 2 = WB.
    typedef struct { bit v; bit w; bit l; int rn; } inst_t;
    inst_t pipe[3];
    int    cnt0, cnt1;
    int    d_rs, d_rt, d_rn, d_pcs;
    bit    d_urs, d_urt, d_wr, d_ld, d_br, d_busy;
    bit    e_stall;

    function automatic bit writes(int s, int r);
        return pipe[s].v && pipe[s].w && (pipe[s].rn == r) && (r != 0);
    endfunction

    function automatic int fwd_sel(int r, bit used);
        if (!used) return 0;
        if (writes(0, r) && !pipe[0].l) return 1;
        if (writes(1, r)) return pipe[1].l ? 3 : 2;
        return 0;
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < 3; s++) begin
            pipe[s].v = 0; pipe[s].w = 0; pipe[s].l = 0; pipe[s].rn = 0;
        end
        cnt0 = 0; cnt1 = 0; e_stall = 0;
    endfunction

    task automatic apply(input int rs, input int rt, input bit urs, input bit urt,
                         input int rn, input bit wr, input bit ld, input bit br,
                         input int pcs, input bit busy);
        d_rs = rs; d_rt = rt; d_urs = urs; d_urt = urt; d_rn = rn;
        d_wr = wr; d_ld = ld; d_br = br; d_pcs = pcs; d_busy = busy;
        bus0.id_rs = 5'(rs); bus0.id_rt = 5'(rt); bus0.id_use_rs = urs; bus0.id_use_rt = urt;
        bus0.id_rn = 5'(rn); bus0.id_wreg = wr; bus0.id_m2reg = ld; bus0.id_branch = br;
        bus0.id_pcsource = 2'(pcs); bus0.mem_busy = busy;
        bus1.id_rs = 5'(rs); bus1.id_rt = 5'(rt); bus1.id_use_rs = urs; bus1.id_use_rt = urt;
        bus1.id_rn = 5'(rn); bus1.id_wreg = wr; bus1.id_m2reg = ld; bus1.id_branch = br;
        bus1.id_pcsource = 2'(pcs); bus1.mem_busy = busy;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check one clock cycle at the falling edge, then step the model.
    task automatic cycle();
        bit dep_exe, dep_mem, haz, st, bb, fz, fl;
        @(negedge clk);
        dep_exe = (d_urs && writes(0, d_rs)) || (d_urt && writes(0, d_rt));
        dep_mem = (d_urs && writes(1, d_rs)) || (d_urt && writes(1, d_rt));
        haz = (dep_exe && pipe[0].l) || (d_br && (dep_exe || (dep_mem && pipe[1].l)));
        fz  = d_busy;
        st  = fz || haz;
        bb  = !fz && haz;
        fl  = !st && (d_pcs != 0);
        check_eq("stall",     bus0.stall,     st);
        check_eq("bubble",    bus0.bubble,    bb);
        check_eq("freeze",    bus0.freeze,    fz);
        check_eq("flush_if",  bus0.flush_if,  fl);
        check_eq("fwda",      bus0.fwda,      fwd_sel(d_rs, d_urs));
        check_eq("fwdb",      bus0.fwdb,      fwd_sel(d_rt, d_urt));
        check_eq("stall_cnt", bus0.stall_cnt, cnt0);
        check_eq("ds_stall",  bus1.stall,     st);
        check_eq("ds_flush",  bus1.flush_if,  1'b0);
        check_eq("sat_cnt",   bus1.stall_cnt, cnt1);
        if (!fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].v  = !bb;
            pipe[0].w  = bb ? 1'b0 : d_wr;
            pipe[0].l  = bb ? 1'b0 : d_ld;
            pipe[0].rn = bb ? 0 : d_rn;
        end
        if (st) begin
            if (cnt0 < 65535) cnt0++;
            if (cnt1 < 7) cnt1++;
        end
        e_stall = st;
        @(posedge clk);
        #1;
    endtask

    // Assert reset and verify outputs drop without waiting for a clock edge.
    task automatic reset_assert();
        clrn = 1'b0;
        #1;
        check_eq("rst_stall",  bus0.stall,     1'b0);
        check_eq("rst_bubble", bus0.bubble,    1'b0);
        check_eq("rst_freeze", bus0.freeze,    1'b0);
        check_eq("rst_flush",  bus0.flush_if,  1'b0);
        check_eq("rst_fwda",   bus0.fwda,      2'b00);
        check_eq("rst_fwdb",   bus0.fwdb,      2'b00);
        check_eq("rst_cnt",    bus0.stall_cnt, 16'd0);
        model_clear();
        #1;
    endtask

    initial begin
        idle();
        reset_assert();
        clrn = 1'b1;
        cycle();

        // Load r3 then add r4,r3,r5.
        apply(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cycle();
        apply(3, 5, 1, 1, 4, 1, 0, 0, 0, 0); cycle(); cycle();
        check_eq("lu_cnt", bus0.stall_cnt, 16'd1);

        // ALU r7 consumed as rt immediately and with one instruction between.
        apply(0, 0, 0, 0, 7, 1, 0, 0, 0, 0); cycle();
        apply(1, 7, 0, 1, 8, 1, 0, 0, 0, 0); cycle();
        apply(0, 0, 0, 0, 7, 1, 0, 0, 0, 0); cycle();
        idle(); cycle();
        apply(1, 7, 0, 1, 9, 1, 0, 0, 0, 0); cycle();

        // r0 never forwards.
        apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); cycle();
        apply(0, 0, 1, 1, 6, 1, 0, 0, 0, 0); cycle();

        // ALU r2 then beq on r2 with redirect request.
        apply(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); cycle();
        apply(2, 0, 1, 1, 0, 0, 0, 1, 1, 0); cycle(); cycle();
        idle(); cycle();

        // Freeze during a load-use stall.
        reset_assert();
        clrn = 1'b1;
        apply(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cycle();
        apply(3, 5, 1, 1, 4, 1, 0, 0, 0, 1); cycle(); cycle(); cycle();
        apply(3, 5, 1, 1, 4, 1, 0, 0, 0, 0); cycle(); cycle();
        check_eq("frz_cnt", bus0.stall_cnt, 16'd4);

        // Reset in the middle of a freeze.
        apply(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); cycle();
        apply(3, 5, 1, 1, 4, 1, 0, 0, 0, 1); cycle();
        reset_assert();
        apply(3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
        clrn = 1'b1;
        cycle();
        check_eq("post_rst_cnt", bus0.stall_cnt, 16'd0);

        for (int i = 0; i < 400; i++) begin
            if (!e_stall || ($urandom_range(0, 3) == 0)) begin
                apply($urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 7) == 0));
            end else begin
                apply(d_rs, d_rt, d_urs, d_urt, d_rn, d_wr, d_ld, d_br, d_pcs,
                      ($urandom_range(0, 7) == 0));
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
